// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use bubbles, taken-branch flushes, dmem wait states with a timeout to HALT.
// Latency: enables/flushes are combinational in the same cycle; the counters update on the next clock edge.
// Backpressure: dmem_ready low freezes every stage; after 1+MEM_TIMEOUT frozen cycles it halts until reset.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       freeze;
   logic       load_use;

   assign freeze = ((state == RUN) && dmem_req && !dmem_ready) ||
                   ((state == MEM_WAIT) && !dmem_ready) ||
                   (state == HALT);

   // x0 never carries a real dependency, so a load into x0 never stalls
   assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     (((id_ex_rd == id_rs1) && id_uses_rs1) ||
                      ((id_ex_rd == id_rs2) && id_uses_rs2));

   assign halted = (state == HALT);

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;

      case (state)
         RUN: begin
            if (dmem_req && !dmem_ready) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase

      // Branch beats load-use: the dependent ID instruction is squashed anyway
      if (!rst && !freeze) begin
         if (ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            id_ex_flush = 1'b1;
         end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (!pc_en && (state != HALT) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (!freeze && ex_branch_taken && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboarded bench for hazard_stall_ctrl, built with a short timeout and 4-bit counters.
module tb_hazard_stall_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   typedef struct {
      logic [6:0]  en;       // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
      logic        halted;
      int          stall;
      int          flush;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, id_ex_rd;
   logic          id_uses_rs1, id_uses_rs2, id_ex_mem_read;
   logic          ex_branch_taken, dmem_req, dmem_ready;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, halted;
   logic [CW-1:0] stall_cycles, flush_count;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model state
   bit   m_wait, m_halt;
   int   m_n, m_stall, m_flush;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
      .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
      id_ex_rd = 5'd9; id_ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   // Inputs are already driven (clk low); predict, push, compare, then clock the model.
   task automatic cycle();
      exp_t e, o;
      bit   frz, lu;
      frz = m_halt || (m_wait && !dmem_ready) || (!m_wait && dmem_req && !dmem_ready);
      lu  = id_ex_mem_read && (id_ex_rd != 0) &&
            ((id_ex_rd == id_rs1 && id_uses_rs1) || (id_ex_rd == id_rs2 && id_uses_rs2));
      if (rst || frz)           e.en = 7'b0000000;
      else if (ex_branch_taken) e.en = 7'b1111111;
      else if (lu)              e.en = 7'b0011101;
      else                      e.en = 7'b1111100;
      e.halted = m_halt;
      e.stall  = m_stall;
      e.flush  = m_flush;
      sb.push_back(e);
      #1;
      o = sb.pop_front();
      check_eq("enables", {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                           if_id_flush, id_ex_flush}, {25'd0, o.en});
      check_eq("halted", {31'd0, halted}, {31'd0, o.halted});
      check_eq("stall_cycles", {28'd0, stall_cycles}, o.stall);
      check_eq("flush_count", {28'd0, flush_count}, o.flush);
      @(posedge clk);
      if (rst) begin
         m_wait = 0; m_halt = 0; m_n = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!e.en[6] && !m_halt && m_stall < SAT) m_stall++;
         if (!frz && ex_branch_taken && m_flush < SAT) m_flush++;
         if (!m_halt) begin
            if (!m_wait) begin
               if (dmem_req && !dmem_ready) begin m_wait = 1; m_n = 1; end
            end else if (dmem_ready) begin
               m_wait = 0;
            end else begin
               m_n++;
               if (m_n == 1 + TMO) begin m_halt = 1; m_wait = 0; end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_wait = 0; m_halt = 0; m_n = 0; m_stall = 0; m_flush = 0;

      // reset state
      do_reset();
      cycle();

      // load-use on rs2, then dependency gone
      id_ex_mem_read = 1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd3;
      cycle();
      idle_inputs();
      cycle();
      check_eq("lu_stall", {28'd0, stall_cycles}, 1);

      // negatives: x0 destination, rd match on an unused source
      id_ex_mem_read = 1; id_ex_rd = 5'd0; id_rs1 = 5'd0;
      cycle();
      idle_inputs();
      id_ex_mem_read = 1; id_ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 0;
      cycle();
      idle_inputs();
      cycle();
      check_eq("neg_stall", {28'd0, stall_cycles}, 1);

      // branch together with load-use
      do_reset();
      ex_branch_taken = 1; id_ex_mem_read = 1; id_ex_rd = 5'd5; id_rs1 = 5'd5;
      cycle();
      idle_inputs();
      cycle();
      check_eq("br_lu_flush", {28'd0, flush_count}, 1);
      check_eq("br_lu_stall", {28'd0, stall_cycles}, 0);

      // memory wait of 3 cycles with a branch pending throughout
      do_reset();
      dmem_req = 1; ex_branch_taken = 1; dmem_ready = 0;
      repeat (3) cycle();
      dmem_ready = 1;
      cycle();
      idle_inputs();
      cycle();
      check_eq("mw_stall", {28'd0, stall_cycles}, 3);
      check_eq("mw_flush", {28'd0, flush_count}, 1);

      // timeout into HALT, then reset out of it
      do_reset();
      dmem_req = 1; dmem_ready = 0;
      repeat (5) cycle();
      check_eq("to_halted", {31'd0, halted}, 1);
      idle_inputs();
      repeat (3) cycle();
      check_eq("to_stall", {28'd0, stall_cycles}, 5);
      do_reset();
      cycle();
      check_eq("to_unhalt", {31'd0, halted}, 0);

      // flush counter saturation
      do_reset();
      ex_branch_taken = 1;
      repeat (20) cycle();
      idle_inputs();
      cycle();
      check_eq("sat_flush", {28'd0, flush_count}, SAT);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         rst             = ($urandom_range(0, 49) == 0);
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_ex_rd        = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom_range(0, 1));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         id_ex_mem_read  = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         dmem_req        = 1'($urandom_range(0, 1));
         dmem_ready      = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
